mem_access_stage: RTL

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage_pkg.sv | 69 ++++++
 rtl/mem_access_stage_load_align.sv | 45 ++++
 rtl/mem_access_stage.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage.
// Holds the mem_op code set, the stage FSM state encoding, the byte-enable
// constants and small decode helpers used by the stage and its lane aligner.
package mem_access_stage_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_SB   = 4'd8,
    OP_SH   = 4'd9,
    OP_SW   = 4'd10
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Unassigned codes collapse to OP_NONE so the rest of the stage only ever
  // sees legal operations.
  function automatic mem_op_e decode_op(input logic [3:0] code);
    decode_op = OP_NONE;
    case (code)
      4'd1:    decode_op = OP_LB;
      4'd2:    decode_op = OP_LBU;
      4'd3:    decode_op = OP_LH;
      4'd4:    decode_op = OP_LHU;
      4'd5:    decode_op = OP_LW;
      4'd8:    decode_op = OP_SB;
      4'd9:    decode_op = OP_SH;
      4'd10:   decode_op = OP_SW;
      default: decode_op = OP_NONE;
    endcase
  endfunction

  function automatic logic is_load(input mem_op_e op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_half(input mem_op_e op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic is_word(input mem_op_e op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  // Halfwords need an even address, words a multiple of four.
  function automatic logic misaligned(input mem_op_e op, input logic [1:0] a);
    return (is_half(op) && a[0]) || (is_word(op) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// load_align: combinational lane extraction and extension for loads.
// Ports:
//   word    - 32-bit word returned by data memory (little-endian lanes)
//   addr    - byte offset within the word (addr[1:0])
//   mem_op  - operation code (only load codes produce a nonzero result)
//   result  - extracted byte/halfword, sign- or zero-extended; LW passes word
module load_align
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [3:0]  mem_op,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
  end

  // Halfword loads are already known to be aligned, so addr[1] alone picks
  // the lane.
  assign half_sel = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    result = '0;
    case (decode_op(mem_op))
      OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  result = {24'd0, byte_sel};
      OP_LH:   result = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  result = {16'd0, half_sel};
      OP_LW:   result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage issuing one data-memory access per op.
// Ports:
//   clk, rst                       - clock, async active-high reset
//   in_valid/in_ready              - upstream handshake (ready only in IDLE)
//   mem_op, addr, store_data,
//   rd_in, wb_en_in                - operation latched on acceptance
//   dm_req/dm_we/dm_be/dm_addr/
//   dm_wdata/dm_ack/dm_rdata       - data-memory request, held until dm_ack
//   out_valid/out_rd/out_data/
//   out_wen                        - one-cycle write-back result
//   misalign_exc                   - pulses with out_valid for misaligned ops
//
// state  | meaning
// IDLE   | waiting for in_valid; in_ready=1
// ACCESS | memory request outstanding until dm_ack
// DONE   | result presented on out_* for one cycle
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  input  logic        wb_en_in,
  output logic        dm_req,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        out_valid,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data,
  output logic        out_wen,
  output logic        misalign_exc
);

  state_e      state, state_nxt;
  mem_op_e     op_in;
  logic        fault_in;

  mem_op_e     op_q;
  logic [31:0] addr_q;
  logic [31:0] sdata_q;
  logic [4:0]  rd_q;
  logic        wben_q;
  logic        fault_q;
  logic [31:0] rdata_q;

  logic [3:0]  be_sel;
  logic [31:0] wdata_sel;
  logic [31:0] load_res;

  assign op_in    = decode_op(mem_op);
  assign fault_in = misaligned(op_in, addr[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= OP_NONE;
      addr_q  <= '0;
      sdata_q <= '0;
      rd_q    <= '0;
      wben_q  <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && in_valid) begin
        op_q    <= op_in;
        addr_q  <= addr;
        sdata_q <= store_data;
        rd_q    <= rd_in;
        wben_q  <= wb_en_in;
        fault_q <= fault_in;
      end
      if ((state == ST_ACCESS) && dm_ack) begin
        rdata_q <= dm_rdata;
      end
    end
  end

  // NONE and faulting ops never touch memory and go straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if ((op_in == OP_NONE) || fault_in) state_nxt = ST_DONE;
          else                                state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: if (dm_ack) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Byte enables and lane-replicated write data from the latched op.
  always_comb begin
    be_sel    = BE_NONE;
    wdata_sel = '0;
    case (op_q)
      OP_LB, OP_LBU: be_sel = BE_BYTE0 << addr_q[1:0];
      OP_SB: begin
        be_sel    = BE_BYTE0 << addr_q[1:0];
        wdata_sel = {4{sdata_q[7:0]}};
      end
      OP_LH, OP_LHU: be_sel = addr_q[1] ? BE_HALF_HI : BE_HALF_LO;
      OP_SH: begin
        be_sel    = addr_q[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_sel = {2{sdata_q[15:0]}};
      end
      OP_LW: be_sel = BE_WORD;
      OP_SW: begin
        be_sel    = BE_WORD;
        wdata_sel = sdata_q;
      end
      default: begin
        be_sel    = BE_NONE;
        wdata_sel = '0;
      end
    endcase
  end

  load_align u_load_align (
    .word   (rdata_q),
    .addr   (addr_q[1:0]),
    .mem_op (op_q),
    .result (load_res)
  );

  // Outputs are decoded from the registered state, so the async reset clears
  // them (and drops dm_req) immediately.
  always_comb begin
    in_ready     = 1'b0;
    dm_req       = 1'b0;
    dm_we        = 1'b0;
    dm_be        = BE_NONE;
    dm_addr      = '0;
    dm_wdata     = '0;
    out_valid    = 1'b0;
    out_rd       = '0;
    out_data     = '0;
    out_wen      = 1'b0;
    misalign_exc = 1'b0;
    case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_ACCESS: begin
        dm_req   = 1'b1;
        dm_we    = is_store(op_q);
        dm_be    = be_sel;
        dm_addr  = {2'b00, addr_q[31:2]};
        dm_wdata = wdata_sel;
      end
      ST_DONE: begin
        out_valid    = 1'b1;
        out_rd       = rd_q;
        misalign_exc = fault_q;
        out_wen      = wben_q && (rd_q != 5'd0) && !is_store(op_q) && !fault_q;
        if (fault_q || is_store(op_q)) out_data = '0;
        else if (is_load(op_q))        out_data = load_res;
        else                           out_data = addr_q;
      end
      default: in_ready = 1'b0;
    endcase
  end

endmodule
